// File: rtl/morse_pkg.sv
// Shared Morse sequence-code constants, FSM state type and small slot helpers.
package morse_pkg;

  localparam logic [1:0] SYM_DOT  = 2'b00;
  localparam logic [1:0] SYM_DASH = 2'b01;
  localparam logic [1:0] SYM_WSP  = 2'b10;
  localparam logic [1:0] SYM_END  = 2'b11;

  localparam logic [9:0] CODE_SPACE   = {SYM_WSP, SYM_END, SYM_END, SYM_END, SYM_END};
  localparam logic [9:0] CODE_INVALID = 10'b11_11_11_11_11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_GAP,
    ST_CGAP,
    ST_WGAP
  } state_t;

  function automatic logic is_element(input logic [1:0] sym);
    return (sym == SYM_DOT) || (sym == SYM_DASH);
  endfunction

  function automatic logic [2:0] elem_units(input logic [1:0] sym);
    return (sym == SYM_DASH) ? 3'd3 : 3'd1;
  endfunction

endpackage

// File: rtl/morse_char_lut.sv
// Combinational ASCII to 10-bit Morse sequence code; lower case folds to upper case.
module morse_char_lut
  import morse_pkg::*;
(
  input  logic [7:0] char_in,
  output logic [9:0] code
);

  logic [7:0] upper;

  always_comb begin
    upper = char_in;
    if (char_in >= 8'h61 && char_in <= 8'h7A) upper = char_in - 8'h20;
    code = CODE_INVALID;
    case (upper)
      8'h20: code = CODE_SPACE;
      8'h41: code = 10'b00_01_11_11_11; // A
      8'h42: code = 10'b01_00_00_00_11;
      8'h43: code = 10'b01_00_01_00_11;
      8'h44: code = 10'b01_00_00_11_11;
      8'h45: code = 10'b00_11_11_11_11;
      8'h46: code = 10'b00_00_01_00_11;
      8'h47: code = 10'b01_01_00_11_11;
      8'h48: code = 10'b00_00_00_00_11;
      8'h49: code = 10'b00_00_11_11_11;
      8'h4A: code = 10'b00_01_01_01_11;
      8'h4B: code = 10'b01_00_01_11_11;
      8'h4C: code = 10'b00_01_00_00_11;
      8'h4D: code = 10'b01_01_11_11_11;
      8'h4E: code = 10'b01_00_11_11_11;
      8'h4F: code = 10'b01_01_01_11_11;
      8'h50: code = 10'b00_01_01_00_11;
      8'h51: code = 10'b01_01_00_01_11;
      8'h52: code = 10'b00_01_00_11_11;
      8'h53: code = 10'b00_00_00_11_11;
      8'h54: code = 10'b01_11_11_11_11;
      8'h55: code = 10'b00_00_01_11_11;
      8'h56: code = 10'b00_00_00_01_11;
      8'h57: code = 10'b00_01_01_11_11;
      8'h58: code = 10'b01_00_00_01_11;
      8'h59: code = 10'b01_00_01_01_11;
      8'h5A: code = 10'b01_01_00_00_11;
      8'h30: code = 10'b01_01_01_01_01; // 0
      8'h31: code = 10'b00_01_01_01_01;
      8'h32: code = 10'b00_00_01_01_01;
      8'h33: code = 10'b00_00_00_01_01;
      8'h34: code = 10'b00_00_00_00_01;
      8'h35: code = 10'b00_00_00_00_00;
      8'h36: code = 10'b01_00_00_00_00;
      8'h37: code = 10'b01_01_00_00_00;
      8'h38: code = 10'b01_01_01_00_00;
      8'h39: code = 10'b01_01_01_01_00;
      default: code = CODE_INVALID;
    endcase
  end

endmodule

// File: rtl/morse_encoder.sv
// Morse transmitter: accepts ASCII characters and keys dots, dashes and gaps
// on key_out, timed in units of UNIT_CYCLES clocks.
module morse_encoder
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic       busy,
  output logic [9:0] code_out,
  output logic       err
);

  localparam int unsigned TW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(UNIT_CYCLES - 1);
  // Closing gaps run one cycle short: the IDLE cycle that presents char_ready
  // is the last gap cycle, so a waiting character keys with no extra idle cycle.
  localparam logic [TW-1:0] TICK_SKIP = (UNIT_CYCLES > 1) ? TW'(1) : TW'(0);
  localparam logic [2:0]    UNIT_TRIM = (UNIT_CYCLES > 1) ? 3'd0 : 3'd1;

  // Handshake: a character transfers on a rising edge where char_valid and
  // char_ready are both high; char_in is ignored at every other edge.
  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    units_q, units_d;
  logic [7:0]    rest_q, rest_d;
  logic [9:0]    code_q, code_d;
  logic          key_q, key_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [9:0]    lut_code;
  logic          unit_done;
  logic          last_unit;

  morse_char_lut u_lut (
    .char_in (char_in),
    .code    (lut_code)
  );

  assign unit_done = (tick_q == TICK_LAST);
  assign last_unit = unit_done && (units_q == 3'd1);

  always_comb begin
    state_d = state_q;
    tick_d  = unit_done ? '0 : tick_q + TW'(1);
    units_d = unit_done ? units_q - 3'd1 : units_q;
    rest_d  = rest_q;
    code_d  = code_q;
    key_d   = key_q;
    ready_d = ready_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (char_valid && ready_q) begin
          ready_d = 1'b0;
          code_d  = lut_code;
          rest_d  = lut_code[7:0];
          if (is_element(lut_code[9:8])) begin
            state_d = ST_MARK;
            units_d = elem_units(lut_code[9:8]);
            tick_d  = '0;
            key_d   = 1'b1;
          end else if (lut_code[9:8] == SYM_WSP) begin
            state_d = ST_WGAP;
            units_d = 3'd4 - UNIT_TRIM;
            tick_d  = TICK_SKIP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_MARK: begin
        if (last_unit) begin
          state_d = ST_GAP;
          units_d = 3'd1;
          tick_d  = '0;
          key_d   = 1'b0;
        end
      end
      ST_GAP: begin
        if (last_unit) begin
          rest_d = {rest_q[5:0], SYM_END};
          if (is_element(rest_q[7:6])) begin
            state_d = ST_MARK;
            units_d = elem_units(rest_q[7:6]);
            tick_d  = '0;
            key_d   = 1'b1;
          end else begin
            state_d = ST_CGAP;
            units_d = 3'd2 - UNIT_TRIM;
            tick_d  = TICK_SKIP;
          end
        end
      end
      ST_CGAP, ST_WGAP: begin
        if (last_unit) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      units_q <= '0;
      rest_q  <= '1;
      code_q  <= CODE_INVALID;
      key_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      units_q <= units_d;
      rest_q  <= rest_d;
      code_q  <= code_d;
      key_q   <= key_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign char_ready = ready_q;
  assign key_out    = key_q;
  assign busy       = busy_q;
  assign code_out   = code_q;
  assign err        = err_q;

endmodule
